// File: rtl/uart_instruction_rx_if.sv
// Serial-side bundle for uart_instruction_rx: the rx line in, the assembled word and strobes out.
// The receiver takes the slave modport; the host/control side takes the master modport.
interface uart_instruction_rx_if;
   logic        rx;
   logic [31:0] instruction;
   logic        instruction_rcv;
   logic        frame_err;

   modport master (
      output rx,
      input  instruction,
      input  instruction_rcv,
      input  frame_err
   );

   modport slave (
      input  rx,
      output instruction,
      output instruction_rcv,
      output frame_err
   );
endinterface

// File: rtl/uart_instruction_rx.sv
// 8N1 UART receiver that packs four little-endian bytes into a 32-bit instruction word.
// Optional inter-byte gap timeout: define UART_RX_TIMEOUT_EN.
module uart_instruction_rx #(
   parameter int CLK_HZ       = 12_000_000,
   parameter int BAUD         = 115_200,
   parameter int TIMEOUT_BITS = 1024
) (
   input logic                 clk12,
   input logic                 rst,
   uart_instruction_rx_if.slave bus
);

   localparam int DIVISOR  = CLK_HZ / BAUD;
   localparam int HALF_DIV = DIVISOR / 2;
   localparam int TIMER_W  = $clog2(DIVISOR);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      WAIT_HIGH
   } state_t;

   state_t               state_q, state_d;
   logic                 sync1_q, sync2_q, rx_prev_q;
   logic [TIMER_W-1:0]   timer_q, timer_d;
   logic [2:0]           bit_cnt_q, bit_cnt_d;
   logic [7:0]           shift_q, shift_d;
   logic [1:0]           byte_cnt_q, byte_cnt_d;
   logic [23:0]          stage_q, stage_d;
   logic [31:0]          instruction_q, instruction_d;
   logic                 rcv_q, rcv_d;
   logic                 ferr_q, ferr_d;
   logic                 rx_s;
   logic                 fall;

`ifdef UART_RX_TIMEOUT_EN
   localparam int GAP_LIMIT = TIMEOUT_BITS * DIVISOR;
   localparam int GAP_W     = $clog2(GAP_LIMIT + 1);
   logic [GAP_W-1:0] gap_q, gap_d;
`endif

   assign rx_s = sync2_q;
   assign fall = rx_prev_q & ~sync2_q;

   // Synchronizer and edge-detect flops preset high so a released reset never looks like a start edge.
   always_ff @(posedge clk12 or posedge rst) begin
      if (rst) begin
         sync1_q   <= 1'b1;
         sync2_q   <= 1'b1;
         rx_prev_q <= 1'b1;
      end else begin
         // NOTE: non-blocking assignments so every flop samples the pre-edge value of its source.
         sync1_q   <= bus.rx;
         sync2_q   <= sync1_q;
         rx_prev_q <= sync2_q;
      end
   end

   always_ff @(posedge clk12 or posedge rst) begin
      if (rst) begin
         state_q       <= IDLE;
         timer_q       <= '0;
         bit_cnt_q     <= '0;
         shift_q       <= '0;
         byte_cnt_q    <= '0;
         stage_q       <= '0;
         instruction_q <= '0;
         rcv_q         <= 1'b0;
         ferr_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         timer_q       <= timer_d;
         bit_cnt_q     <= bit_cnt_d;
         shift_q       <= shift_d;
         byte_cnt_q    <= byte_cnt_d;
         stage_q       <= stage_d;
         instruction_q <= instruction_d;
         rcv_q         <= rcv_d;
         ferr_q        <= ferr_d;
      end
   end

`ifdef UART_RX_TIMEOUT_EN
   always_ff @(posedge clk12 or posedge rst) begin
      if (rst) gap_q <= '0;
      else     gap_q <= gap_d;
   end
`endif

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      state_d       = state_q;
      timer_d       = timer_q;
      bit_cnt_d     = bit_cnt_q;
      shift_d       = shift_q;
      byte_cnt_d    = byte_cnt_q;
      stage_d       = stage_q;
      instruction_d = instruction_q;
      rcv_d         = 1'b0;
      ferr_d        = 1'b0;
`ifdef UART_RX_TIMEOUT_EN
      gap_d         = '0;
`endif

      case (state_q)
         IDLE: begin
            if (fall) begin
               state_d = START;
               timer_d = '0;
            end
`ifdef UART_RX_TIMEOUT_EN
            else if (byte_cnt_q != 2'd0) begin
               // A stalled partial word is dropped silently once the gap limit is reached.
               if (gap_q == GAP_W'(GAP_LIMIT - 1)) byte_cnt_d = 2'd0;
               else                                gap_d      = gap_q + 1'b1;
            end
`endif
         end

         START: begin
            if (timer_q == TIMER_W'(HALF_DIV - 1)) begin
               timer_d = '0;
               if (!rx_s) begin
                  state_d   = DATA;
                  bit_cnt_d = '0;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end

         DATA: begin
            if (timer_q == TIMER_W'(DIVISOR - 1)) begin
               timer_d = '0;
               shift_d = {rx_s, shift_q[7:1]};
               if (bit_cnt_q == 3'd7) state_d   = STOP;
               else                   bit_cnt_d = bit_cnt_q + 1'b1;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end

         STOP: begin
            if (timer_q == TIMER_W'(DIVISOR - 1)) begin
               timer_d = '0;
               if (rx_s) begin
                  state_d = IDLE;
                  case (byte_cnt_q)
                     2'd0: stage_d[7:0]   = shift_q;
                     2'd1: stage_d[15:8]  = shift_q;
                     2'd2: stage_d[23:16] = shift_q;
                     default: begin
                        instruction_d = {shift_q, stage_q};
                        rcv_d         = 1'b1;
                     end
                  endcase
                  byte_cnt_d = byte_cnt_q + 1'b1;
               end else begin
                  state_d    = WAIT_HIGH;
                  byte_cnt_d = 2'd0;
                  ferr_d     = 1'b1;
               end
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end

         WAIT_HIGH: begin
            if (rx_s) state_d = IDLE;
         end

         default: state_d = IDLE;
      endcase
   end

   assign bus.instruction     = instruction_q;
   assign bus.instruction_rcv = rcv_q;
   assign bus.frame_err       = ferr_q;

endmodule

// File: tb/tb_uart_instruction_rx.sv
// Directed bench for uart_instruction_rx: a byte-level model pushes expected words to a queue,
// and a negedge monitor pops and compares them whenever the DUT strobes instruction_rcv.
module tb_uart_instruction_rx;

   localparam int CLK_HZ          = 12_000_000;
   localparam int BAUD            = 115_200;
   localparam int DIV             = CLK_HZ / BAUD;
   // Gap limit shortened so the timeout scenario fits a short run.
   localparam int TB_TIMEOUT_BITS = 32;

   logic clk12 = 1'b0;
   logic rst   = 1'b1;

   uart_instruction_rx_if bus ();

   uart_instruction_rx #(
      .CLK_HZ       (CLK_HZ),
      .BAUD         (BAUD),
      .TIMEOUT_BITS (TB_TIMEOUT_BITS)
   ) dut (
      .clk12 (clk12),
      .rst   (rst),
      .bus   (bus)
   );

   always #41 clk12 = ~clk12;

   int          vectors     = 0;
   int          miscompares = 0;
   logic [31:0] exp_q[$];
   int          model_cnt   = 0;
   logic [31:0] model_stage = '0;
   logic [31:0] last_exp    = '0;
   int          exp_total   = 0;
   int          exp_ferr    = 0;
   int          rcv_seen    = 0;
   int          ferr_seen   = 0;
   logic        rcv_prev    = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clk12);
   endtask

   // Drives one 8N1 frame; the model is updated before the stop bit so the
   // expected word is queued ahead of the DUT's strobe.
   task automatic send_byte(input logic [7:0] b, input bit stop_ok);
      bus.rx = 1'b0;
      cycles(DIV);
      for (int i = 0; i < 8; i++) begin
         bus.rx = b[i];
         cycles(DIV);
      end
      if (stop_ok) begin
         model_stage[8*model_cnt +: 8] = b;
         if (model_cnt == 3) begin
            exp_q.push_back(model_stage);
            last_exp = model_stage;
            exp_total++;
            model_cnt = 0;
         end else begin
            model_cnt++;
         end
      end else begin
         model_cnt = 0;
         exp_ferr++;
      end
      bus.rx = stop_ok;
      cycles(DIV);
      bus.rx = 1'b1;
      if (!stop_ok) cycles(2 * DIV);
   endtask

   task automatic send_word(input logic [31:0] w);
      for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1);
   endtask

   task automatic wait_drain(input string tag);
      int n = 0;
      while (exp_q.size() != 0 && n < 4 * DIV) begin
         @(negedge clk12);
         n++;
      end
      check({tag, "_drain"}, exp_q.size(), 0);
      check({tag, "_word"}, bus.instruction, last_exp);
   endtask

   always @(negedge clk12) begin
      if (bus.instruction_rcv === 1'b1) begin
         rcv_seen++;
         check("strobe_overlap", bus.frame_err, 1'b0);
         check("strobe_width", rcv_prev, 1'b0);
         vectors++;
         assert (exp_q.size() != 0) else begin
            miscompares++;
            $error("FAIL unexpected_strobe: observed instruction %h expected no strobe", bus.instruction);
         end
         if (exp_q.size() != 0) check("instruction", bus.instruction, exp_q.pop_front());
      end
      if (bus.frame_err === 1'b1) ferr_seen++;
      rcv_prev <= bus.instruction_rcv;
   end

   initial begin
      bus.rx = 1'b1;
      rst    = 1'b1;
      cycles(5);
      rst = 1'b0;
      cycles(2);
      check("reset_instruction", bus.instruction, 32'h0);
      check("reset_rcv", bus.instruction_rcv, 1'b0);
      check("reset_ferr", bus.frame_err, 1'b0);
      cycles(10000);
      check("idle_rcv_count", rcv_seen, 0);
      check("idle_ferr_count", ferr_seen, 0);

      // Single word; no strobe may appear after the first three bytes.
      send_byte(8'h13, 1'b1);
      send_byte(8'h05, 1'b1);
      send_byte(8'h10, 1'b1);
      check("partial_no_strobe", rcv_seen, 0);
      check("partial_holds", bus.instruction, 32'h0);
      send_byte(8'h00, 1'b1);
      wait_drain("word1");
      check("word1_value", bus.instruction, 32'h0010_0513);
      check("word1_count", rcv_seen, 1);

      // Back-to-back words with no idle gap beyond the stop bit.
      send_word(32'h0000_0013);
      send_word(32'h0000_00B3);
      wait_drain("b2b");
      check("b2b_count", rcv_seen, 3);

      // Short low glitch while idle must not be counted as a byte.
      bus.rx = 1'b0;
      cycles(20);
      bus.rx = 1'b1;
      cycles(2 * DIV);
      send_word(32'hDEAD_BEEF);
      wait_drain("glitch");
      check("glitch_value", bus.instruction, 32'hDEAD_BEEF);

      // Bad stop bit: one frame_err, counter cleared, next word intact.
      send_byte(8'h13, 1'b0);
      check("ferr_count", ferr_seen, exp_ferr);
      send_word(32'h0403_0201);
      wait_drain("after_ferr");
      check("after_ferr_value", bus.instruction, 32'h0403_0201);

      // Reset in the middle of a frame discards the partial word.
      send_byte(8'hAA, 1'b1);
      send_byte(8'hBB, 1'b1);
      bus.rx = 1'b0;
      cycles(3 * DIV);
      rst = 1'b1;
      cycles(5);
      bus.rx = 1'b1;
      cycles(5);
      rst = 1'b0;
      model_cnt = 0;
      last_exp  = 32'h0;
      cycles(2);
      check("midreset_instruction", bus.instruction, 32'h0);
      send_word(32'h4433_2211);
      wait_drain("midreset");

      // Stalled partial word followed by a long idle gap.
      send_byte(8'h34, 1'b1);
      send_byte(8'h12, 1'b1);
      cycles((TB_TIMEOUT_BITS + 8) * DIV);
`ifdef UART_RX_TIMEOUT_EN
      model_cnt = 0;
`endif
      send_byte(8'h78, 1'b1);
      send_byte(8'h56, 1'b1);
      send_byte(8'h34, 1'b1);
      send_byte(8'h12, 1'b1);
      wait_drain("timeout");
`ifdef UART_RX_TIMEOUT_EN
      check("timeout_value", bus.instruction, 32'h1234_5678);
`else
      check("timeout_value", bus.instruction, 32'h5678_1234);
`endif

      cycles(2 * DIV);
      check("final_rcv_count", rcv_seen, exp_total);
      check("final_ferr_count", ferr_seen, exp_ferr);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
